// File: rtl/rgb2ycbcr_if.sv
// Pixel stream bundle for the colour-space converter: RGB/sync/mode in,
// converted pixel, aligned syncs, position counters and mode out.
interface rgb2ycbcr_if #(
   parameter int COLORDEPTH = 8,
   parameter int XW         = 11,
   parameter int YW         = 11
);
   logic [3*COLORDEPTH-1:0] rgb_i;
   logic                    dv_i;
   logic                    hs_i;
   logic                    vs_i;
   logic [1:0]              mode_i;

   logic [3*COLORDEPTH-1:0] pix_o;
   logic [COLORDEPTH-1:0]   y_o;
   logic                    dv_o;
   logic                    hs_o;
   logic                    vs_o;
   logic                    line_start_o;
   logic                    frame_start_o;
   logic [XW-1:0]           x_o;
   logic [YW-1:0]           y_line_o;
   logic [1:0]              mode_o;

   modport master (
      output rgb_i, dv_i, hs_i, vs_i, mode_i,
      input  pix_o, y_o, dv_o, hs_o, vs_o, line_start_o, frame_start_o,
             x_o, y_line_o, mode_o
   );

   modport slave (
      input  rgb_i, dv_i, hs_i, vs_i, mode_i,
      output pix_o, y_o, dv_o, hs_o, vs_o, line_start_o, frame_start_o,
             x_o, y_line_o, mode_o
   );
endinterface

// File: rtl/rgb2ycbcr.sv
// BT.601 full-range RGB -> Y/Cb/Cr / gray / bypass converter, fixed 3-stage
// pipeline with delay-matched syncs, position counters and frame-latched mode.
module rgb2ycbcr #(
   parameter int COLORDEPTH = 8,
   parameter int XW         = 11,
   parameter int YW         = 11
) (
   input  logic       clk,
   input  logic       rst,
   rgb2ycbcr_if.slave bus
);
   localparam int CD = COLORDEPTH;
   localparam int AW = CD + 10;
   localparam int PW = 3 * CD;

   localparam logic signed [AW-1:0] RND_S = AW'(128);
   localparam logic signed [AW-1:0] MID_S = AW'(2 ** (CD - 1));
   localparam logic signed [AW-1:0] MAX_S = AW'(2 ** CD - 1);
   localparam logic [CD-1:0]        MID_U = CD'(2 ** (CD - 1));
   localparam logic [CD-1:0]        MAX_U = '1;

   // Row-major {Y, Cb, Cr} x {R, G, B}, 8 fractional bits.
   localparam int COEF_TAB [9] = '{77, 150, 29, -43, -85, 128, 128, -107, -21};

   typedef enum logic [1:0] {
      M_GRAY   = 2'd0,
      M_YCBCR  = 2'd1,
      M_BYPASS = 2'd2,
      M_LUMA   = 2'd3
   } mode_t;

   typedef struct packed {
      logic [PW-1:0] rgb;
      logic          dv;
      logic          hs;
      logic          vs;
      logic          ls;
      logic          fs;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      mode_t         mode;
   } side_t;

   // Input-side edge detectors and counters
   logic          dv_prev_q, dv_prev_d;
   logic          vs_prev_q, vs_prev_d;
   logic [XW-1:0] x_cnt_q, x_cnt_d;
   logic [YW-1:0] y_cnt_q, y_cnt_d;
   mode_t         mode_act_q, mode_act_d;

   logic          dv_rise, dv_fall, vs_rise;
   logic [XW-1:0] x_cur;
   logic [YW-1:0] y_cur;
   mode_t         mode_cur;

   // Pipeline registers
   side_t                  s1_q, s1_d;
   side_t                  s2_q, s2_d;
   logic signed [AW-1:0]   prod_q [9];
   logic signed [AW-1:0]   prod_d [9];
   logic signed [AW-1:0]   sum_q [3];
   logic signed [AW-1:0]   sum_d [3];
   logic signed [AW-1:0]   rnd [3];
   logic [CD-1:0]          chan_sat [3];

   // Output registers
   logic [PW-1:0] pix_q, pix_d;
   logic [CD-1:0] luma_q, luma_d;
   logic          dv_q, dv_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          ls_q, ls_d;
   logic          fs_q, fs_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] yl_q, yl_d;
   mode_t         mode_q, mode_d;
   logic [PW-1:0] pix_mux;

   // Stage 1: nine channel x coefficient products
   for (genvar gi = 0; gi < 9; gi++) begin : g_prod
      localparam int                   COL  = gi % 3;
      localparam logic signed [AW-1:0] COEF = AW'(COEF_TAB[gi]);
      assign prod_d[gi] = $signed({{(AW - CD){1'b0}}, bus.rgb_i[(2 - COL)*CD +: CD]}) * COEF;
   end

   // Stage 2 sums and stage 3 round/offset/saturate, one per output channel
   for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      localparam logic signed [AW-1:0] OFFS = (gi == 0) ? AW'(0) : MID_S;
      assign sum_d[gi]    = prod_q[3*gi] + prod_q[3*gi + 1] + prod_q[3*gi + 2];
      assign rnd[gi]      = ((sum_q[gi] + RND_S) >>> 8) + OFFS;
      assign chan_sat[gi] = rnd[gi][AW-1]    ? '0 :
                            (rnd[gi] > MAX_S) ? MAX_U : rnd[gi][CD-1:0];
   end

   always_comb begin
      dv_rise = bus.dv_i & ~dv_prev_q;
      dv_fall = ~bus.dv_i & dv_prev_q;
      vs_rise = bus.vs_i & ~vs_prev_q;

      // A rising edge clears, so a new line or frame index always starts at 0.
      x_cur    = dv_rise ? '0 : (bus.dv_i ? x_cnt_q + 1'b1 : x_cnt_q);
      y_cur    = vs_rise ? '0 : y_cnt_q;
      mode_cur = vs_rise ? mode_t'(bus.mode_i) : mode_act_q;

      dv_prev_d  = bus.dv_i;
      vs_prev_d  = bus.vs_i;
      x_cnt_d    = x_cur;
      y_cnt_d    = vs_rise ? '0 : (dv_fall ? y_cnt_q + 1'b1 : y_cnt_q);
      mode_act_d = mode_cur;

      s1_d.rgb  = bus.rgb_i;
      s1_d.dv   = bus.dv_i;
      s1_d.hs   = bus.hs_i;
      s1_d.vs   = bus.vs_i;
      s1_d.ls   = dv_rise;
      s1_d.fs   = vs_rise;
      s1_d.x    = x_cur;
      s1_d.y    = y_cur;
      s1_d.mode = mode_cur;
      s2_d      = s1_q;

      case (s2_q.mode)
         M_GRAY:   pix_mux = {chan_sat[0], chan_sat[0], chan_sat[0]};
         M_YCBCR:  pix_mux = {chan_sat[0], chan_sat[1], chan_sat[2]};
         M_BYPASS: pix_mux = s2_q.rgb;
         default:  pix_mux = {chan_sat[0], MID_U, MID_U};
      endcase

      pix_d  = s2_q.dv ? pix_mux : '0;
      luma_d = s2_q.dv ? chan_sat[0] : '0;
      dv_d   = s2_q.dv;
      hs_d   = s2_q.hs;
      vs_d   = s2_q.vs;
      ls_d   = s2_q.ls;
      fs_d   = s2_q.fs;
      x_d    = s2_q.x;
      yl_d   = s2_q.y;
      mode_d = s2_q.mode;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dv_prev_q  <= 1'b0;
         vs_prev_q  <= 1'b0;
         x_cnt_q    <= '0;
         y_cnt_q    <= '0;
         mode_act_q <= M_GRAY;
         s1_q       <= '0;
         s2_q       <= '0;
         for (int i = 0; i < 9; i++) prod_q[i] <= '0;
         for (int i = 0; i < 3; i++) sum_q[i] <= '0;
         pix_q      <= '0;
         luma_q     <= '0;
         dv_q       <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         ls_q       <= 1'b0;
         fs_q       <= 1'b0;
         x_q        <= '0;
         yl_q       <= '0;
         mode_q     <= M_GRAY;
      end else begin
         dv_prev_q  <= dv_prev_d;
         vs_prev_q  <= vs_prev_d;
         x_cnt_q    <= x_cnt_d;
         y_cnt_q    <= y_cnt_d;
         mode_act_q <= mode_act_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
         for (int i = 0; i < 3; i++) sum_q[i] <= sum_d[i];
         pix_q      <= pix_d;
         luma_q     <= luma_d;
         dv_q       <= dv_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         ls_q       <= ls_d;
         fs_q       <= fs_d;
         x_q        <= x_d;
         yl_q       <= yl_d;
         mode_q     <= mode_d;
      end
   end

   assign bus.pix_o         = pix_q;
   assign bus.y_o           = luma_q;
   assign bus.dv_o          = dv_q;
   assign bus.hs_o          = hs_q;
   assign bus.vs_o          = vs_q;
   assign bus.line_start_o  = ls_q;
   assign bus.frame_start_o = fs_q;
   assign bus.x_o           = x_q;
   assign bus.y_line_o      = yl_q;
   assign bus.mode_o        = mode_q;
endmodule
